// File: rtl/bcd_count_mod.sv
// Up/down BCD counter modulo MODULUS with synchronous clear and validated load.
// Emits combinational carry/borrow strobes so instances cascade on one clock.
module bcd_count_mod #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  count_carry,
  output logic                  count_borrow,
  output logic                  load_err
);
  localparam int W = 4*DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [W-1:0]      bcd_q, bcd_d;
  logic              load_err_q, load_err_d;
  logic [W-1:0]      inc_val, dec_val;
  logic [DIGITS-1:0] inc_c, dec_b, nib_ok;
  logic              at_max, at_zero, load_ok;

  // inc_c/dec_b[g]: every digit below g is 9 (resp. 0), so digit g steps
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      logic [3:0] d;
      assign d = bcd_q[4*g +: 4];
      if (g == 0) begin : g_lsd
        assign inc_c[g] = 1'b1;
        assign dec_b[g] = 1'b1;
      end else begin : g_hsd
        assign inc_c[g] = inc_c[g-1] & (bcd_q[4*(g-1) +: 4] == 4'd9);
        assign dec_b[g] = dec_b[g-1] & (bcd_q[4*(g-1) +: 4] == 4'd0);
      end
      assign inc_val[4*g +: 4] = !inc_c[g] ? d : (d == 4'd9) ? 4'd0 : d + 4'd1;
      assign dec_val[4*g +: 4] = !dec_b[g] ? d : (d == 4'd0) ? 4'd9 : d - 4'd1;
      assign nib_ok[g] = (load_val[4*g +: 4] <= 4'd9);
    end
  endgenerate

  assign at_max  = (bcd_q == MAX_BCD);
  assign at_zero = (bcd_q == '0);
  // With all nibbles legal, packed-BCD ordering equals decimal ordering
  assign load_ok = (&nib_ok) && (load_val <= MAX_BCD);

  always_comb begin
    bcd_d      = bcd_q;
    load_err_d = 1'b0;
    if (clr) begin
      bcd_d = '0;
    end else if (load) begin
      if (load_ok) bcd_d = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (up) bcd_d = at_max  ? '0      : inc_val;
      else    bcd_d = at_zero ? MAX_BCD : dec_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      load_err_q <= load_err_d;
    end
  end

  assign bcd_out      = bcd_q;
  assign load_err     = load_err_q;
  assign count_carry  = reset & en &  up & ~clr & ~load & at_max;
  assign count_borrow = reset & en & ~up & ~clr & ~load & at_zero;
endmodule

// File: tb/tb_bcd_count_mod.sv
// Directed bench for bcd_count_mod: seconds field (mod 60) cascaded into an
// hours field (mod 24) through count_carry.
module tb_bcd_count_mod;
  logic       clk, reset, clr, load, en, up;
  logic [7:0] load_val;
  logic [7:0] sec_bcd, hr_bcd;
  logic       sec_c, sec_b, sec_err, hr_c, hr_b, hr_err;
  logic [7:0] hr_lv;

  int n_chk  = 0;
  int n_fail = 0;

  assign hr_lv = 8'h00;

  bcd_count_mod #(.DIGITS(2), .MODULUS(60)) u_sec (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .bcd_out(sec_bcd), .count_carry(sec_c),
    .count_borrow(sec_b), .load_err(sec_err));

  bcd_count_mod #(.DIGITS(2), .MODULUS(24)) u_hr (
    .clk(clk), .reset(reset), .clr(clr), .load(1'b0), .load_val(hr_lv),
    .en(sec_c), .up(1'b1), .bcd_out(hr_bcd), .count_carry(hr_c),
    .count_borrow(hr_b), .load_err(hr_err));

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       clr, load;
    logic [7:0] lv;
    logic       en, up;
    logic [7:0] exp_bcd;
    logic       exp_c, exp_b, exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int s, h;
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h59, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h58, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h57, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h45, 1'b1, 1'b1, 8'h45, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h6A, 1'b1, 1'b1, 8'h45, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h45, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h60, 1'b1, 1'b0, 8'h45, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h46, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hA0, 1'b1, 1'b1, 8'h46, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h59, 1'b0, 1'b1, 8'h59, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h59, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h59, 1'b0, 1'b0, 8'h59, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h59, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h37, 1'b0, 1'b1, 8'h37, 1'b0, 1'b0, 1'b0});

    // Reset phase: borrow must stay low even with en=1, up=0 at value 0
    reset = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b1; up = 1'b0;
    #50;
    chk("rst_bcd", sec_bcd, 8'h00);
    chk("rst_err", sec_err, 1'b0);
    chk("rst_borrow", sec_b, 1'b0);
    up = 1'b1;
    #1;
    chk("rst_carry", sec_c, 1'b0);
    #49;
    reset = 1'b1;

    // Full up-count 00..59 -> 00
    s = 0;
    for (int i = 0; i < 60; i++) begin
      #4;
      chk("up_bcd", sec_bcd, to_bcd(s));
      chk("up_carry", sec_c, (s == 59));
      chk("up_nibbles", (sec_bcd[3:0] <= 4'd9) && (sec_bcd[7:4] <= 4'd9), 1'b1);
      @(posedge clk); #1;
      s = (s + 1) % 60;
    end
    chk("up_wrap", sec_bcd, 8'h00);
    chk("hr_after_60", hr_bcd, 8'h01);

    for (int i = 0; i < tbl.size(); i++) begin
      clr = tbl[i].clr; load = tbl[i].load; load_val = tbl[i].lv;
      en = tbl[i].en; up = tbl[i].up;
      #4;
      chk($sformatf("v%0d_carry", i), sec_c, tbl[i].exp_c);
      chk($sformatf("v%0d_borrow", i), sec_b, tbl[i].exp_b);
      @(posedge clk); #1;
      chk($sformatf("v%0d_bcd", i), sec_bcd, tbl[i].exp_bcd);
      chk($sformatf("v%0d_err", i), sec_err, tbl[i].exp_err);
    end

    // Asynchronous reset mid-cycle at 0x37
    clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    #4;
    reset = 1'b0;
    #2;
    chk("async_rst_bcd", sec_bcd, 8'h00);
    chk("async_rst_carry", sec_c, 1'b0);
    @(posedge clk); #1;
    chk("async_rst_hold", sec_bcd, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("resume_bcd", sec_bcd, 8'h01);

    // Cascade: clear both fields, then 60*24 enabled edges
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("casc_clr_sec", sec_bcd, 8'h00);
    chk("casc_clr_hr", hr_bcd, 8'h00);
    s = 0; h = 0;
    for (int i = 0; i < 60*24; i++) begin
      #4;
      if (i == 60*24 - 1) begin
        chk("casc_last_sec", sec_bcd, 8'h59);
        chk("casc_last_hr", hr_bcd, 8'h23);
        chk("casc_last_carry", sec_c, 1'b1);
      end
      @(posedge clk); #1;
      if (s == 59) h = (h + 1) % 24;
      s = (s + 1) % 60;
      if (sec_bcd !== to_bcd(s) || hr_bcd !== to_bcd(h)) begin
        chk("casc_sec", sec_bcd, to_bcd(s));
        chk("casc_hr", hr_bcd, to_bcd(h));
      end
    end
    chk("casc_end_sec", sec_bcd, 8'h00);
    chk("casc_end_hr", hr_bcd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
